// File: rtl/rv32_types.sv
// rv32_types: shared memory-op encodings, mem-stage FSM states and op classifiers.
package rv32_types;

    typedef enum logic [3:0] {
        MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} mem_state_t;

    function automatic logic is_load(mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

endpackage

// File: rtl/rv32_store_align.sv
// rv32_store_align: byte enables, lane-replicated store data and misalignment for one op.
module rv32_store_align
    import rv32_types::*;
(
    input  mem_op_t     op,
    input  logic [1:0]  addr,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned
);

    always_comb begin
        be = op == MEM_SB ? 4'b0001 << addr :
             op == MEM_SH ? (addr[1] ? 4'b1100 : 4'b0011) :
             (op == MEM_SW || is_load(op)) ? 4'b1111 : 4'b0000;
        wdata = op == MEM_SB ? {4{data[7:0]}} :
                op == MEM_SH ? {2{data[15:0]}} :
                op == MEM_SW ? data : 32'h0;
        misaligned = (op inside {MEM_LH, MEM_LHU, MEM_SH} && addr[0]) ||
                     (op inside {MEM_LW, MEM_SW} && addr != 2'b00);
    end

endmodule

// File: rtl/rv32_mem_access.sv
// rv32_mem_access: memory stage; issues aligned bus requests and hands raw load words,
// completion and fault status to writeback.
module rv32_mem_access
    import rv32_types::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  mem_op_t     in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_store_data,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_we,
    output logic [3:0]  req_be,
    output logic [31:0] req_wdata,
    input  logic        resp_valid,
    input  logic [31:0] resp_rdata,
    output logic        wb_valid,
    output mem_op_t     wb_op,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_raw_load,
    output logic        wb_fault_misaligned,
    output logic        wb_fault_timeout
);

    localparam int CW = TIMEOUT_W < 1 ? 1 : TIMEOUT_W;

    mem_state_t  r_state, w_next;
    logic [CW-1:0] r_cnt;
    mem_op_t     r_op;
    logic [31:0] r_addr;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_mis, w_accept, w_go, w_done_imm;
    logic        w_hs_st, w_hs_ld, w_hs_rsp, w_to;

    rv32_store_align u_align (
        .op        (in_op),
        .addr      (in_addr[1:0]),
        .data      (in_store_data),
        .be        (w_be),
        .wdata     (w_wdata),
        .misaligned(w_mis)
    );

    assign in_ready   = r_state == IDLE;
    assign req_valid  = r_state == REQ;
    assign w_accept   = in_valid && in_ready;
    assign w_go       = w_accept && (is_load(in_op) || is_store(in_op)) && !w_mis;
    assign w_done_imm = w_accept && !w_go;
    assign w_hs_st    = r_state == REQ && req_ready && req_we;
    assign w_hs_ld    = r_state == REQ && req_ready && !req_we;
    assign w_hs_rsp   = r_state == WAIT_RESP && resp_valid;
    // A handshake landing on the expiry cycle completes normally rather than faulting.
    assign w_to = TIMEOUT_CYCLES != 0 && r_state != IDLE && r_cnt >= CW'(TIMEOUT_CYCLES - 1) &&
                  !(w_hs_st || w_hs_ld || w_hs_rsp);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = w_go ? REQ : IDLE;
            REQ:       w_next = w_hs_st ? IDLE : w_hs_ld ? WAIT_RESP : w_to ? IDLE : REQ;
            WAIT_RESP: w_next = (w_hs_rsp || w_to) ? IDLE : WAIT_RESP;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt               <= '0;
            r_op                <= MEM_NOP;
            r_addr              <= '0;
            req_addr            <= '0;
            req_we              <= 1'b0;
            req_be              <= '0;
            req_wdata           <= '0;
            wb_valid            <= 1'b0;
            wb_op               <= MEM_NOP;
            wb_addr             <= '0;
            wb_raw_load         <= '0;
            wb_fault_misaligned <= 1'b0;
            wb_fault_timeout    <= 1'b0;
        end else begin
            if (w_accept) r_cnt <= '0;
            else if (r_state != IDLE) r_cnt <= r_cnt + 1'b1;
            wb_valid <= w_done_imm || w_hs_st || w_hs_rsp || w_to;
            if (w_go) begin
                r_op      <= in_op;
                r_addr    <= in_addr;
                req_addr  <= {in_addr[31:2], 2'b00};
                req_we    <= is_store(in_op);
                req_be    <= w_be;
                req_wdata <= w_wdata;
            end
            if (w_done_imm) begin
                wb_op               <= in_op;
                wb_addr             <= in_addr;
                wb_raw_load         <= '0;
                wb_fault_misaligned <= w_mis;
                wb_fault_timeout    <= 1'b0;
            end
            if (w_hs_st || w_hs_rsp || w_to) begin
                wb_op               <= r_op;
                wb_addr             <= r_addr;
                wb_raw_load         <= w_hs_rsp ? resp_rdata : 32'h0;
                wb_fault_misaligned <= 1'b0;
                wb_fault_timeout    <= w_to;
            end
        end
    end

endmodule
